fetch_unit: RTL and testbench

Parametrised instruction-fetch front end for the pipelined MIPS core. It generates fetch PCs, issues one-cycle-latency requests to the synchronous instruction ROM, and buffers returned instructions with their PCs in a DEPTH-entry queue. It presents them to decode with a valid/ready handshake. A redirect from execute (taken branch, j, jal, jr, jalr) flushes all wrong-path work. It sits between the instruction ROM and the IF/ID pipeline register, and decouples decode stalls from fetch.

---
 rtl/fetch_pkg.sv | 13 +
 rtl/fetch_if.sv | 28 ++
 rtl/fetch_fifo.sv | 51 +++++
 rtl/fetch_unit.sv | 87 ++++++++
 tb/tb_fetch_unit.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and entry type for the instruction-fetch front end.
package fetch_pkg;

  localparam int INST_BYTES = 4;
  localparam logic [31:0] NOP_INST = 32'h0000_0000;
  localparam int PC_BITS = 32;

  typedef struct packed {
    logic [31:0]        inst;
    logic [PC_BITS-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_if.sv
// Fetch-unit bus: ROM request/response, execute redirect and decode handshake.
interface fetch_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
);

  logic                         redirect_valid;
  logic [ADDR_WIDTH-1:0]        redirect_pc;
  logic                         imem_req;
  logic [ADDR_WIDTH-1:0]        imem_addr;
  logic [31:0]                  imem_data;
  logic                         inst_valid;
  logic [31:0]                  inst_data;
  logic [ADDR_WIDTH-1:0]        inst_pc;
  logic                         inst_ready;
  logic [$clog2(DEPTH+1)-1:0]   count;

  modport master (
    input  redirect_valid, redirect_pc, imem_data, inst_ready,
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc, count
  );

  modport slave (
    output redirect_valid, redirect_pc, imem_data, inst_ready,
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc, count
  );

endinterface

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {inst, pc} entries with push, pop, flush and occupancy.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  entry_t                     push_entry,
  input  logic                       pop,
  input  logic                       flush,
  output entry_t                     head_entry,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  entry_t        mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      // Empty the queue by collapsing head onto tail; tail stays put.
      head  <= tail;
      count <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      if (push && !pop)
        count <= count + CW'(1);
      else if (!push && pop)
        count <= count - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push && !flush)
      mem[tail] <= push_entry;
  end

  assign head_entry = mem[head];

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC generation, ROM request credit, redirect flush and decode queue.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DEPTH      = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic   clock,
  input  logic   reset,
  fetch_if.master bus
);

  localparam int CW  = $clog2(DEPTH+1);
  localparam int CW1 = CW + 1;

  typedef struct packed {
    logic [31:0]           inst;
    logic [ADDR_WIDTH-1:0] pc;
  } entry_t;

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic [ADDR_WIDTH-1:0] req_pc;
  logic [ADDR_WIDTH-1:0] target_pc;
  logic                  inflight;
  logic                  kill;
  logic                  inst_valid;
  logic                  pop;
  logic                  push;
  logic                  issue;
  logic [CW-1:0]         count;
  logic [CW1-1:0]        credit;
  entry_t                head_entry;
  entry_t                push_entry;

  assign inst_valid = (count != '0);
  assign pop        = inst_valid & bus.inst_ready & ~bus.redirect_valid;
  assign push       = inflight & ~kill & ~bus.redirect_valid;

  // Slots already spoken for, counting the response still in flight and
  // crediting back a same-cycle pop so a drained queue refills without a bubble.
  assign credit = {1'b0, count} + CW1'(inflight) - CW1'(pop);
  assign issue  = reset & ~bus.redirect_valid & (credit < CW1'(DEPTH));

  assign target_pc  = bus.redirect_pc & ~ADDR_WIDTH'(INST_BYTES - 1);
  assign push_entry = '{inst: bus.imem_data, pc: req_pc};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      kill     <= 1'b0;
    end else begin
      inflight <= issue;
      kill     <= bus.redirect_valid & inflight;
      if (issue)
        req_pc <= fetch_pc;
      if (bus.redirect_valid)
        fetch_pc <= target_pc;
      else if (issue)
        fetch_pc <= fetch_pc + ADDR_WIDTH'(INST_BYTES);
    end
  end

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (bus.redirect_valid),
    .head_entry (head_entry),
    .count      (count)
  );

  assign bus.imem_req   = issue;
  assign bus.imem_addr  = fetch_pc;
  assign bus.inst_valid = inst_valid;
  assign bus.inst_data  = inst_valid ? head_entry.inst : NOP_INST;
  assign bus.inst_pc    = inst_valid ? head_entry.pc : '0;
  assign bus.count      = count;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed-vector bench for fetch_unit: streaming, stall/refill, redirects, PC wrap and async reset.
module tb_fetch_unit;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  fetch_if #(.ADDR_WIDTH(32), .DEPTH(4)) bus0 ();
  fetch_if #(.ADDR_WIDTH(32), .DEPTH(4)) bus1 ();

  fetch_unit #(.ADDR_WIDTH(32), .DEPTH(4), .RESET_PC(32'h0000_0000)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (bus0)
  );

  fetch_unit #(.ADDR_WIDTH(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (bus1)
  );

  // ROM model: word[n] = n, one-cycle read latency.
  always @(posedge clock) begin
    bus0.imem_data <= bus0.imem_addr >> 2;
    bus1.imem_data <= bus1.imem_addr >> 2;
  end

  typedef struct {
    bit          ready;
    bit          redir;
    logic [31:0] rpc;
    bit          req;
    logic [31:0] addr;
    bit          valid;
    logic [31:0] pc;
    logic [31:0] data;
    logic [31:0] cnt;
  } vec_t;

  vec_t tbl [16];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic vec_t mk(bit ready, bit redir, logic [31:0] rpc, bit req, logic [31:0] addr,
                              bit valid, logic [31:0] pc, logic [31:0] data, logic [31:0] cnt);
    vec_t v;
    v.ready = ready; v.redir = redir; v.rpc = rpc;
    v.req = req; v.addr = addr; v.valid = valid;
    v.pc = pc; v.data = data; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_out(string tag, bit req, logic [31:0] addr, bit valid,
                         logic [31:0] pc, logic [31:0] data, logic [31:0] cnt);
    chk({tag, "_req"},   32'(bus0.imem_req),   32'(req));
    chk({tag, "_addr"},  bus0.imem_addr,       addr);
    chk({tag, "_valid"}, 32'(bus0.inst_valid), 32'(valid));
    chk({tag, "_pc"},    bus0.inst_pc,         pc);
    chk({tag, "_data"},  bus0.inst_data,       data);
    chk({tag, "_count"}, 32'(bus0.count),      cnt);
  endtask

  task automatic chk_wrap(string tag, bit valid, logic [31:0] addr, logic [31:0] pc, logic [31:0] data);
    chk({tag, "_req"},   32'(bus1.imem_req),   32'd1);
    chk({tag, "_addr"},  bus1.imem_addr,       addr);
    chk({tag, "_valid"}, 32'(bus1.inst_valid), 32'(valid));
    chk({tag, "_pc"},    bus1.inst_pc,         pc);
    chk({tag, "_data"},  bus1.inst_data,       data);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    //            rdy  rdir  rpc           req  addr          vld  pc            data          cnt
    tbl[0]  = mk(1'b1, 1'b0, 32'h0,       1'b1, 32'h0,       1'b0, 32'h0,       32'h0,  32'd0);
    tbl[1]  = mk(1'b1, 1'b0, 32'h0,       1'b1, 32'h4,       1'b0, 32'h0,       32'h0,  32'd0);
    tbl[2]  = mk(1'b1, 1'b0, 32'h0,       1'b1, 32'h8,       1'b1, 32'h0,       32'h0,  32'd1);
    tbl[3]  = mk(1'b1, 1'b0, 32'h0,       1'b1, 32'hC,       1'b1, 32'h4,       32'h1,  32'd1);
    tbl[4]  = mk(1'b1, 1'b0, 32'h0,       1'b1, 32'h10,      1'b1, 32'h8,       32'h2,  32'd1);
    tbl[5]  = mk(1'b0, 1'b0, 32'h0,       1'b1, 32'h14,      1'b1, 32'hC,       32'h3,  32'd1);
    tbl[6]  = mk(1'b0, 1'b0, 32'h0,       1'b1, 32'h18,      1'b1, 32'hC,       32'h3,  32'd2);
    tbl[7]  = mk(1'b0, 1'b0, 32'h0,       1'b0, 32'h1C,      1'b1, 32'hC,       32'h3,  32'd3);
    tbl[8]  = mk(1'b0, 1'b0, 32'h0,       1'b0, 32'h1C,      1'b1, 32'hC,       32'h3,  32'd4);
    tbl[9]  = mk(1'b1, 1'b0, 32'h0,       1'b1, 32'h1C,      1'b1, 32'hC,       32'h3,  32'd4);
    tbl[10] = mk(1'b1, 1'b0, 32'h0,       1'b1, 32'h20,      1'b1, 32'h10,      32'h4,  32'd3);
    tbl[11] = mk(1'b1, 1'b1, 32'h103,     1'b0, 32'h24,      1'b1, 32'h14,      32'h5,  32'd3);
    tbl[12] = mk(1'b1, 1'b0, 32'h0,       1'b1, 32'h100,     1'b0, 32'h0,       32'h0,  32'd0);
    tbl[13] = mk(1'b1, 1'b0, 32'h0,       1'b1, 32'h104,     1'b0, 32'h0,       32'h0,  32'd0);
    tbl[14] = mk(1'b1, 1'b0, 32'h0,       1'b1, 32'h108,     1'b1, 32'h100,     32'h40, 32'd1);
    tbl[15] = mk(1'b1, 1'b0, 32'h0,       1'b1, 32'h10C,     1'b1, 32'h104,     32'h41, 32'd1);

    reset               = 1'b0;
    bus0.inst_ready     = 1'b1;
    bus0.redirect_valid = 1'b0;
    bus0.redirect_pc    = 32'h0;
    bus1.inst_ready     = 1'b1;
    bus1.redirect_valid = 1'b0;
    bus1.redirect_pc    = 32'h0;

    // Reset state while held low.
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req",   32'(bus0.imem_req),   32'd0);
    chk("rst_valid", 32'(bus0.inst_valid), 32'd0);
    chk("rst_count", 32'(bus0.count),      32'd0);
    step();
    reset = 1'b1;

    for (int i = 0; i < 16; i++) begin
      bus0.inst_ready     = tbl[i].ready;
      bus0.redirect_valid = tbl[i].redir;
      bus0.redirect_pc    = tbl[i].rpc;
      #1;
      chk_out($sformatf("v%0d", i), tbl[i].req, tbl[i].addr, tbl[i].valid,
              tbl[i].pc, tbl[i].data, tbl[i].cnt);
      step();
    end

    // Back-to-back redirects: only the second target reaches decode.
    bus0.redirect_valid = 1'b1;
    bus0.redirect_pc    = 32'h200;
    #1;
    chk_out("bb0", 1'b0, 32'h110, 1'b1, 32'h108, 32'h42, 32'd1);
    step();
    bus0.redirect_pc = 32'h300;
    #1;
    chk_out("bb1", 1'b0, 32'h200, 1'b0, 32'h0, 32'h0, 32'd0);
    step();
    bus0.redirect_valid = 1'b0;
    bus0.redirect_pc    = 32'h0;
    #1;
    chk_out("bb2", 1'b1, 32'h300, 1'b0, 32'h0, 32'h0, 32'd0);
    step();
    #1;
    chk_out("bb3", 1'b1, 32'h304, 1'b0, 32'h0, 32'h0, 32'd0);
    step();
    #1;
    chk_out("bb4", 1'b1, 32'h308, 1'b1, 32'h300, 32'hC0, 32'd1);
    step();
    #1;
    chk_out("bb5", 1'b1, 32'h30C, 1'b1, 32'h304, 32'hC1, 32'd1);
    step();

    // Stall one cycle so two entries are queued, then reset mid-stream.
    bus0.inst_ready = 1'b0;
    #1;
    chk_out("st0", 1'b1, 32'h310, 1'b1, 32'h308, 32'hC2, 32'd1);
    step();
    #1;
    chk_out("st1", 1'b1, 32'h314, 1'b1, 32'h308, 32'hC2, 32'd2);
    reset = 1'b0;
    #1;
    chk("mrst_req",   32'(bus0.imem_req),   32'd0);
    chk("mrst_valid", 32'(bus0.inst_valid), 32'd0);
    chk("mrst_count", 32'(bus0.count),      32'd0);
    chk("mrst_pc",    bus0.inst_pc,         32'h0);
    chk("mrst_req1",  32'(bus1.imem_req),   32'd0);
    step();
    chk("mrst_hold_req", 32'(bus0.imem_req), 32'd0);
    step();
    reset           = 1'b1;
    bus0.inst_ready = 1'b1;
    #1;
    chk_out("rs0", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 32'd0);
    chk_wrap("w0", 1'b0, 32'hFFFF_FFF8, 32'h0, 32'h0);
    step();
    #1;
    chk_out("rs1", 1'b1, 32'h4, 1'b0, 32'h0, 32'h0, 32'd0);
    chk_wrap("w1", 1'b0, 32'hFFFF_FFFC, 32'h0, 32'h0);
    step();
    #1;
    chk_out("rs2", 1'b1, 32'h8, 1'b1, 32'h0, 32'h0, 32'd1);
    chk_wrap("w2", 1'b1, 32'h0, 32'hFFFF_FFF8, 32'h3FFF_FFFE);
    step();
    #1;
    chk_wrap("w3", 1'b1, 32'h4, 32'hFFFF_FFFC, 32'h3FFF_FFFF);
    step();
    #1;
    chk_wrap("w4", 1'b1, 32'h8, 32'h0, 32'h0);
    step();
    #1;
    chk_wrap("w5", 1'b1, 32'hC, 32'h4, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
